ldr_input_conditioner: RTL
==========================

# ldr_input_conditioner

Front-end stage for the smart-home light sensor path. It takes the raw, asynchronous LDR comparator pin, synchronises it to the board clock, and debounces it against a divided sample tick. It delivers a clean, glitch-free `LDR` level to the downstream LDR/LED lamp-control stage, plus optional one-cycle change pulses for the status logic.

## Interface

Parameters:
- `SAMPLE_DIV`, default 50000. Board clocks per sample tick (1 kHz at 50 MHz). Legal range is 2 or more.
- `DEBOUNCE_N`, default 8. Consecutive disagreeing samples required to change `LDR`. Legal range is 1 or more.

Ports:
- `CLK_IN`, in, 1 bit. Board clock. Single clock domain; all state updates on the rising edge.
- `RST`, in, 1 bit. Synchronous, active-high reset.
- `LDR_RAW`, in, 1 bit. Asynchronous sensor comparator output. 1 = light, 0 = dark.
- `LDR`, out, 1 bit. Debounced, registered light level. This feeds the lamp-control stage.
- `SAMPLE_TICK`, out, 1 bit. One-cycle strobe on each sample instant.
- `LDR_RISE`, out, 1 bit. One-cycle pulse when `LDR` goes 0→1. Present only with `LDR_EDGE_EN`.
- `LDR_FALL`, out, 1 bit. One-cycle pulse when `LDR` goes 1→0. Present only with `LDR_EDGE_EN`.

## Operation

- **Synchroniser:** two-flop chain, `LDR_RAW` → `s1` → `s2`. `s2` is the only sampled value; `LDR_RAW` is never used elsewhere.
- **Prescaler:**
  - `div_cnt` is `$clog2(SAMPLE_DIV)` bits wide and counts 0 to `SAMPLE_DIV-1`, then wraps to 0.
  - `SAMPLE_TICK` = (`div_cnt == SAMPLE_DIV-1`). It is registered, so it is high for exactly one cycle per `SAMPLE_DIV` cycles.
- **Debounce:** `agree_cnt` is `$clog2(DEBOUNCE_N+1)` bits wide. Action only on cycles where `SAMPLE_TICK` is high:
  - `s2 == LDR`: `agree_cnt` ← 0.
  - `s2 != LDR` and `agree_cnt == DEBOUNCE_N-1`: `LDR` ← `s2`, `agree_cnt` ← 0.
  - `s2 != LDR` otherwise: `agree_cnt` ← `agree_cnt + 1`.
- **Tick gating:** on non-tick cycles, `agree_cnt` and `LDR` hold.
- **Glitch rejection:** a single agreeing sample anywhere in the run discards the partial count. A glitch shorter than `DEBOUNCE_N` consecutive ticks never reaches `LDR`.
- **`DEBOUNCE_N = 1`:** `LDR` follows `s2` on every tick.
- **State machine:** implicit two states, STABLE (`agree_cnt == 0`) and PENDING (`agree_cnt > 0`).
  - STABLE → PENDING on the first disagreeing tick.
  - PENDING → STABLE on an agreeing tick (no change to `LDR`) or on the commit tick (`LDR` toggles).
- **Edge pulses:** `LDR_RISE` / `LDR_FALL` are asserted in the same cycle `LDR` takes its new value. Both are high for exactly one cycle and are never high together.
- **Reset** (synchronous, takes priority over everything):
  - `s1`, `s2`, `div_cnt`, `agree_cnt` ← 0.
  - `LDR` ← 0 (dark, so the lamp-on default downstream is safe).
  - `SAMPLE_TICK`, `LDR_RISE`, `LDR_FALL` ← 0.
- **Reset mid-operation:** a pending count is discarded and `LDR` returns to 0 regardless of its previous value. No edge pulse is generated by reset.

## Timing

- **Synchroniser delay:** 2 cycles from an `LDR_RAW` edge to `s2`.
- **First tick:** first `SAMPLE_TICK` comes `SAMPLE_DIV` cycles after the cycle in which `RST` is sampled low. Ticks then repeat every `SAMPLE_DIV` cycles.
- **Change latency:** a clean, held `LDR_RAW` change reaches `LDR` between `2 + (DEBOUNCE_N-1)*SAMPLE_DIV + 1` and `2 + DEBOUNCE_N*SAMPLE_DIV` cycles, depending on tick phase.
- **Output registration:** `LDR` changes only in the cycle following a tick-qualified edge and is registered, with no combinational path from `LDR_RAW`. Edge pulses are aligned with the `LDR` transition cycle.
- **Inter-change spacing:** at least `DEBOUNCE_N*SAMPLE_DIV` cycles between any two `LDR` changes.

## Configuration

- **Macro:** `LDR_EDGE_EN`.
- **Defined:** `LDR_RISE` / `LDR_FALL` are generated as described, using one extra register holding the previous `LDR`.
- **Undefined:** both ports remain in the port list but are tied to constant 0, and the previous-`LDR` register is not built. `LDR` and `SAMPLE_TICK` behaviour is identical in both builds.

## Test plan

Bench uses `SAMPLE_DIV=4`, `DEBOUNCE_N=3`. Build both with and without `LDR_EDGE_EN`.

1. **Reset values:** hold `RST` high for 3 cycles with `LDR_RAW=1` → all outputs 0 throughout. After release, `SAMPLE_TICK` first high in cycle 4, then every 4th cycle.
2. **Clean rise:** `LDR_RAW` 0→1 and held → `LDR` rises within 11–14 cycles. `LDR_RISE` is high for exactly 1 cycle, coincident with the `LDR` rise, and `LDR_FALL` stays 0. Without the macro, both pulse outputs stay 0.
3. **Glitch rejection:** with `LDR=0`, pulse `LDR_RAW` high for 6 cycles → `LDR` stays 0 for the following 40 cycles and no pulses occur.
4. **Interrupted run:** with `LDR=1`, drive `LDR_RAW` low for 2 ticks, high for 1 tick, then low and held → `LDR` falls only after 3 further consecutive low ticks. `LDR_FALL` is asserted exactly once.
5. **Reset mid-pending:** start a 0→1 change, then assert `RST` for 1 cycle after the 2nd disagreeing tick → `LDR` stays 0. With `LDR_RAW` still 1, `LDR` rises 3 full ticks after the reset release.
6. **Reset from light:** with `LDR=1`, assert `RST` → `LDR` reads 0 in the next cycle with no `LDR_FALL` pulse. With `LDR_RAW` still 1, `LDR` returns to 1 after 3 ticks.

Source files
------------

// File: rtl/ldr_input_conditioner.sv
// LDR comparator front end: 2-flop synchroniser, sample-tick prescaler and tick-qualified debouncer.
// Optional LDR_RISE/LDR_FALL change pulses are built only when LDR_EDGE_EN is defined.
module ldr_input_conditioner #(
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned DEBOUNCE_N = 8
) (
    input  logic CLK_IN,
    input  logic RST,
    input  logic LDR_RAW,
    output logic LDR,
    output logic SAMPLE_TICK,
    output logic LDR_RISE,
    output logic LDR_FALL
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned AGR_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [AGR_W-1:0] AGR_LAST = AGR_W'(DEBOUNCE_N - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic [AGR_W-1:0] agree_cnt_q, agree_cnt_d;
    logic             ldr_q, ldr_d;

    always_comb begin
        s1_d        = LDR_RAW;
        s2_d        = s1_q;
        tick_d      = (div_cnt_q == DIV_LAST);
        div_cnt_d   = tick_d ? '0 : div_cnt_q + DIV_W'(1);
        agree_cnt_d = agree_cnt_q;
        ldr_d       = ldr_q;
        // agree_cnt == 0 is STABLE, anything else is PENDING a change
        if (tick_q) begin
            if (s2_q == ldr_q) begin
                agree_cnt_d = '0;
            end else if (agree_cnt_q == AGR_LAST) begin
                ldr_d       = s2_q;
                agree_cnt_d = '0;
            end else begin
                agree_cnt_d = agree_cnt_q + AGR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            div_cnt_q   <= '0;
            tick_q      <= 1'b0;
            agree_cnt_q <= '0;
            ldr_q       <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            div_cnt_q   <= div_cnt_d;
            tick_q      <= tick_d;
            agree_cnt_q <= agree_cnt_d;
            ldr_q       <= ldr_d;
        end
    end

    assign LDR         = ldr_q;
    assign SAMPLE_TICK = tick_q;

`ifdef LDR_EDGE_EN
    logic ldr_prev_q, ldr_prev_d;

    always_comb begin
        ldr_prev_d = ldr_q;
    end

    // Reset clears both registers together, so reset never produces a pulse.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            ldr_prev_q <= 1'b0;
        end else begin
            ldr_prev_q <= ldr_prev_d;
        end
    end

    assign LDR_RISE = ldr_q & ~ldr_prev_q;
    assign LDR_FALL = ~ldr_q & ldr_prev_q;
`else
    assign LDR_RISE = 1'b0;
    assign LDR_FALL = 1'b0;
`endif

endmodule
